wb_trace_buffer: RTL and testbench



---
 rtl/wb_trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 87 ++++++++
 rtl/wb_trace_buffer.sv | 111 +++++++++++
 tb/tb_wb_trace_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types and widths for the writeback trace buffer.
package wb_trace_pkg;

    localparam int TRACE_CNT_W  = 32;
    localparam int DROP_CNT_W   = 16;
    localparam int TRACE_REG_W  = 5;
    localparam int TRACE_DATA_W = 32;

    // One captured register write as seen by the debug consumer.
    typedef struct packed {
        logic [TRACE_REG_W-1:0]  rd;
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_DATA_W-1:0] pc;
    } trace_entry_t;

    // Saturating increment used by the drop counter.
    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
        if (v == {DROP_CNT_W{1'b1}}) begin
            return v;
        end
        return v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy output.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Qualify requests against the current occupancy so a careless parent cannot corrupt state.
    always_comb begin
        do_pop  = pop & (level_q != '0);
        do_push = push & ((level_q != LVL_W'(DEPTH)) | do_pop);
    end

    // Next-state for pointers, occupancy and storage; flush wins over any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; entries are only visible through level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head entry falls through combinationally from the read pointer.
    always_comb begin
        rd_data = mem_q[rd_ptr_q];
        valid   = (level_q != '0);
        full    = (level_q == LVL_W'(DEPTH));
        level   = level_q;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback-stage observer: filters retired register writes into a trace FIFO
// and keeps retire/drop statistics for the debug consumer.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int FILTER_ZERO = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         regwriteW,
    input  logic [REG_W-1:0]             rdW,
    input  logic [DATA_W-1:0]            resultW,
    input  logic [DATA_W-1:0]            pcplus4W,
    input  logic                         trace_en,
    input  logic                         flush,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [REG_W-1:0]             trace_rd,
    output logic [DATA_W-1:0]            trace_data,
    output logic [DATA_W-1:0]            trace_pc,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic [TRACE_CNT_W-1:0]       retire_cnt,
    output logic [DROP_CNT_W-1:0]        drop_cnt,
    output logic                         overflow
);

    localparam int ENTRY_W = REG_W + 2*DATA_W;

    logic                   zero_hit;
    logic                   cap;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [DATA_W-1:0]      pc_adj;
    logic [ENTRY_W-1:0]     entry_in;
    logic [ENTRY_W-1:0]     entry_out;
    logic [TRACE_CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   overflow_q, overflow_d;

    // Capture filter and push/drop arbitration; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        zero_hit = (FILTER_ZERO != 0) && (rdW == '0);
        cap      = trace_en & regwriteW & ~zero_hit;
        pop      = trace_valid & trace_ready;
        push     = cap & (~full | pop);
        drop     = cap & full & ~pop;
        pc_adj   = pcplus4W - DATA_W'(4);
        entry_in = {rdW, resultW, pc_adj};
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (entry_in),
        .pop     (pop),
        .flush   (flush),
        .rd_data (entry_out),
        .valid   (trace_valid),
        .full    (full),
        .level   (level)
    );

    // Statistics next-state; a flush cycle neither counts nor drops its capture.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        if (!flush) begin
            if (push) begin
                retire_cnt_d = retire_cnt_q + TRACE_CNT_W'(1);
            end
            if (drop) begin
                drop_cnt_d = sat_inc_drop(drop_cnt_q);
                overflow_d = 1'b1;
            end
        end
    end

    // Statistics registers; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    // Unpack the head entry and expose the counters.
    always_comb begin
        trace_rd   = entry_out[ENTRY_W-1 -: REG_W];
        trace_data = entry_out[2*DATA_W-1 -: DATA_W];
        trace_pc   = entry_out[DATA_W-1:0];
        retire_cnt = retire_cnt_q;
        drop_cnt   = drop_cnt_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: directed test-plan scenarios followed by random traffic.
module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [31:0] pcplus4W;
    logic        trace_en;
    logic        flush;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [31:0] trace_pc;
    logic [4:0]  level;
    logic        full;
    logic [31:0] retire_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    wb_trace_buffer #(.DEPTH(DEPTH), .DATA_W(32), .REG_W(5), .FILTER_ZERO(1)) dut (
        .clk(clk), .rst(rst), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
        .pcplus4W(pcplus4W), .trace_en(trace_en), .flush(flush), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_rd(trace_rd), .trace_data(trace_data),
        .trace_pc(trace_pc), .level(level), .full(full), .retire_cnt(retire_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: expected FIFO contents and statistics.
    trace_entry_t exp_q[$];
    int unsigned  exp_retire;
    int unsigned  exp_drop;
    bit           exp_ovf;
    bit           mon_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; called just after a rising edge, returns just after the next one.
    task automatic step(input bit rw, input logic [4:0] rd, input logic [31:0] res,
                        input logic [31:0] pc4, input bit en, input bit fl,
                        input bit rdy, input bit rs);
        int           cnt;
        bit           m_cap, m_pop, m_push, m_drop;
        trace_entry_t e;
        regwriteW   = rw;
        rdW         = rd;
        resultW     = res;
        pcplus4W    = pc4;
        trace_en    = en;
        flush       = fl;
        trace_ready = rdy;
        rst         = rs;
        cnt    = exp_q.size();
        m_cap  = en && rw && (rd != 0);
        m_pop  = (cnt != 0) && rdy;
        m_push = m_cap && ((cnt < DEPTH) || m_pop);
        m_drop = m_cap && (cnt == DEPTH) && !m_pop;
        e.rd   = rd;
        e.data = res;
        e.pc   = pc4 - 32'd4;
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            exp_retire = 0;
            exp_drop   = 0;
            exp_ovf    = 1'b0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (m_push) begin
                exp_q.push_back(e);
                exp_retire++;
            end
            if (m_drop) begin
                if (exp_drop < 32'hFFFF) exp_drop++;
                exp_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, rdy, 1'b0);
    endtask

    // Monitor: checks status each cycle mid-period and pops the scoreboard on every accepted entry.
    initial begin
        trace_entry_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            chk("valid", {31'd0, trace_valid}, {31'd0, exp_q.size() != 0});
            chk("level", {27'd0, level}, exp_q.size());
            chk("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
            chk("retire_cnt", retire_cnt, exp_retire);
            chk("drop_cnt", {16'd0, drop_cnt}, exp_drop);
            chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            if (trace_valid && trace_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_empty: DUT presented rd=%0d with nothing expected at %0t",
                             trace_rd, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("trace_rd", {27'd0, trace_rd}, {27'd0, e.rd});
                    chk("trace_data", trace_data, e.data);
                    chk("trace_pc", trace_pc, e.pc);
                end
            end
        end
    end

    initial begin
        int unsigned saved;
        bit          rdy;
        rst = 1'b1; regwriteW = 1'b0; rdW = '0; resultW = '0; pcplus4W = '0;
        trace_en = 1'b0; flush = 1'b0; trace_ready = 1'b0;
        exp_retire = 0; exp_drop = 0; exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        chk("reset_valid", {31'd0, trace_valid}, 32'd0);
        chk("reset_full", {31'd0, full}, 32'd0);

        // Single write, visible one cycle later.
        step(1'b1, 5'd8, 32'h1234, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_valid", {31'd0, trace_valid}, 32'd1);
        chk("single_rd", {27'd0, trace_rd}, 32'd8);
        chk("single_data", trace_data, 32'h1234);
        chk("single_pc", trace_pc, 32'h3C);
        chk("single_level", {27'd0, level}, 32'd1);
        chk("single_retire", retire_cnt, 32'd1);
        idle(1'b1);

        // Register 0 is filtered.
        step(1'b1, 5'd0, 32'hDEAD, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("zero_level", {27'd0, level}, 32'd0);
        chk("zero_retire", retire_cnt, 32'd1);

        // Fill past capacity with the consumer stalled.
        for (int i = 1; i <= 18; i++)
            step(1'b1, i[4:0], $urandom, 32'h100 + 32'(4*i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_drop", {16'd0, drop_cnt}, 32'd2);
        chk("fill_ovf", {31'd0, overflow}, 32'd1);

        // Push into a full FIFO with a simultaneous pop; pcplus4W=0 wraps.
        step(1'b1, 5'd19, 32'hCAFE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fullpop_level", {27'd0, level}, 32'd16);
        chk("fullpop_drop", {16'd0, drop_cnt}, 32'd2);
        for (int i = 0; i < 16; i++) idle(1'b1);
        chk("drained_level", {27'd0, level}, 32'd0);

        // Flush mid-stream together with a capture.
        for (int i = 0; i < 5; i++)
            step(1'b1, 5'(i + 3), $urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
        saved = exp_retire;
        step(1'b1, 5'd7, 32'h55, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush_level", {27'd0, level}, 32'd0);
        chk("flush_valid", {31'd0, trace_valid}, 32'd0);
        chk("flush_retire", retire_cnt, saved);
        chk("flush_ovf", {31'd0, overflow}, 32'd1);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(i + 9), $urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_valid", {31'd0, trace_valid}, 32'd0);

        // Random traffic with alternating slow/fast consumer phases.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) < 100) rdy = ($urandom_range(0, 99) < 20);
            else                 rdy = ($urandom_range(0, 99) < 80);
            step($urandom_range(0, 99) < 70,
                 5'($urandom_range(0, 31)),
                 $urandom,
                 ($urandom_range(0, 19) == 0) ? 32'd0 : $urandom,
                 $urandom_range(0, 99) < 90,
                 $urandom_range(0, 99) < 2,
                 rdy,
                 $urandom_range(0, 999) < 3);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
